// File: rtl/int_to_fp32_seq.sv
// int_to_fp32_seq
// Multi-cycle 32-bit integer to FP32 converter. An operand is accepted in
// IDLE. It is normalized one bit per cycle in NORM, rounded to nearest-even
// in ROUND, and then held in DONE until the consumer takes it.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   in_valid     operand valid
//   in_ready     block idle and able to accept (low while reset is low)
//   in_int       32-bit integer operand
//   in_unsigned  1: operand is unsigned, 0: two's complement
//   out_valid    result valid (registered)
//   out_ready    consumer accepts result
//   result       FP32 result (registered)
module int_to_fp32_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state;
    logic        sign;
    logic [31:0] mag;
    logic [7:0]  exp_q;

    logic        in_sign;
    logic        round_up;
    logic [23:0] rnd_sum;

    assign in_ready = reset & (state == IDLE);
    assign in_sign  = in_int[31] & ~in_unsigned;

    // Round to nearest even on the normalized magnitude. The top bit is the
    // hidden one, so the 23 stored bits sit at [30:8]. Bit 7 is the guard
    // bit and [6:0] is the sticky field. A carry out of the 24-bit sum means
    // the mantissa wrapped to zero and the exponent must bump.
    always_comb begin
        round_up = mag[7] & ((|mag[6:0]) | mag[8]);
        rnd_sum  = {1'b0, mag[30:8]} + {23'd0, round_up};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= '0;
            exp_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_int == 32'd0) begin
                            result    <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // The most negative signed value negates to itself.
                            // Read as unsigned, that is the correct magnitude.
                            sign  <= in_sign;
                            mag   <= in_sign ? (~in_int + 32'd1) : in_int;
                            exp_q <= 8'd158;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= ROUND;
                    end else begin
                        mag   <= {mag[30:0], 1'b0};
                        exp_q <= exp_q - 8'd1;
                    end
                end
                ROUND: begin
                    result    <= {sign, exp_q + {7'd0, rnd_sum[23]}, rnd_sum[22:0]};
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp32_seq.sv
// Directed bench for int_to_fp32_seq. A reference model computes the
// correctly rounded FP32 value and its latency from plain integer
// arithmetic. A negedge monitor checks in_ready, out_valid and result
// against a queue of expected conversions on every cycle.
module tb_int_to_fp32_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_int;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    int_to_fp32_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_int(in_int), .in_unsigned(in_unsigned), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   cnt    = 0;
    int   nerr   = 0;
    bit   mon_en = 1'b0;
    bit   chk_rst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ck(input string nm, input logic [31:0] a, input logic [31:0] e);
        cnt++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Reference: the value is exact up to 24 significant bits. Beyond that,
    // the discarded remainder is compared against half an ulp.
    function automatic logic [31:0] model(input logic [31:0] v, input bit uns, output int lz);
        logic        s;
        logic [31:0] m;
        int          p, sh, e;
        longint      man, rem, half;
        s = v[31] & ~uns;
        m = s ? (32'd0 - v) : v;
        if (m == 32'd0) begin
            lz = -1;
            return 32'd0;
        end
        p = 31;
        while (m[p] == 1'b0) p--;
        lz = 31 - p;
        e  = 127 + p;
        if (p <= 23) begin
            man = longint'(m) << (23 - p);
        end else begin
            sh   = p - 23;
            man  = longint'(m) >> sh;
            rem  = longint'(m) & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && man[0])) man++;
            if (man == (64'd1 << 24)) begin
                man = man >> 1;
                e++;
            end
        end
        return {s, e[7:0], man[22:0]};
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            int   lz;
            exp_t x;
            if (chk_rst) begin
                ck("reset_result", result, 32'd0);
                chk_rst = 1'b0;
            end
            ck("in_ready", {31'd0, in_ready}, {31'd0, reset && q.size() == 0});
            if (q.size() == 0)
                ck("out_valid_idle", {31'd0, out_valid}, 32'd0);
            else if (cyc < q[0].due)
                ck("out_valid_early", {31'd0, out_valid}, 32'd0);
            else begin
                ck("out_valid_due", {31'd0, out_valid}, 32'd1);
                ck("result", result, q[0].res);
            end
            if (!reset) begin
                q.delete();
                chk_rst = 1'b1;
            end else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    x.res = model(in_int, in_unsigned, lz);
                    x.due = (lz < 0) ? cyc + 1 : cyc + 1 + lz + 2;
                    q.push_back(x);
                end
            end
        end
    end

    // Called at posedge+1. Waits for in_ready, then presents the operand
    // for exactly one cycle.
    task automatic send(input logic [31:0] v, input bit u);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        cnt++;
        if (!in_ready) begin
            nerr++;
            $display("FAIL send_timeout: in_ready=%b expected 1 for %h", in_ready, v);
        end else begin
            in_valid    = 1'b1;
            in_int      = v;
            in_unsigned = u;
            @(posedge clk); #1;
            in_valid    = 1'b0;
            in_int      = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && q.size() == 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        cnt++;
        if (!(in_ready && q.size() == 0)) begin
            nerr++;
            $display("FAIL idle_timeout: pending=%0d expected 0", q.size());
        end
    endtask

    logic [31:0] vec_v [14] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                32'h01000001, 32'h01000003, 32'hFFFFFFFF, 32'h00000000,
                                32'h00000000, 32'h7FFFFFFF, 32'h12345678, 32'h80000001,
                                32'h00FFFFFF, 32'h00800000};
    bit          vec_u [14] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int lz;
        reset = 1'b0; in_valid = 1'b0; in_int = '0; in_unsigned = 1'b0; out_ready = 1'b1;

        // These literal results pin the model itself.
        ck("m_one",      model(32'h00000001, 0, lz), 32'h3F800000);
        ck("m_one_lz",   lz, 31);
        ck("m_neg1",     model(32'hFFFFFFFF, 0, lz), 32'hBF800000);
        ck("m_minint",   model(32'h80000000, 0, lz), 32'hCF000000);
        ck("m_minint_lz", lz, 0);
        ck("m_u80",      model(32'h80000000, 1, lz), 32'h4F000000);
        ck("m_tie_even", model(32'h01000001, 0, lz), 32'h4B800000);
        ck("m_tie_up",   model(32'h01000003, 0, lz), 32'h4B800002);
        ck("m_carry",    model(32'hFFFFFFFF, 1, lz), 32'h4F800000);
        ck("m_zero",     model(32'h00000000, 1, lz), 32'h00000000);

        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 14; i++) send(vec_v[i], vec_u[i]);
        wait_idle();

        // Backpressure: hold the result for 10 cycles.
        out_ready = 1'b0;
        send(32'h00012345, 0);
        for (int n = 0; n < 100 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_idle();

        // Input noise while busy in NORM.
        send(32'h00000001, 0);
        repeat (20) begin
            in_valid    = $urandom_range(0, 1);
            in_int      = $urandom;
            in_unsigned = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset pulse during NORM aborts the conversion.
        send(32'h00000001, 0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        send(32'h01000003, 0);
        wait_idle();

        // Random operands.
        repeat (20) send($urandom, $urandom_range(0, 1));
        wait_idle();

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, nerr);
        $finish;
    end

endmodule

// File: doc/int_to_fp32_seq.md
# int_to_fp32_seq

Multi-cycle converter from a 32-bit integer to an FP32 (1 sign, 8 exponent bits biased by 127, 23 mantissa bits). It is the encode side of our FP32 datapath: the adder consumes FP32 operands, and this block produces them from integer sources. The design has one small FSM with valid/ready handshakes on both sides. Normalization uses one bit shift per cycle, and rounding is round-to-nearest-even.

## Interface
No parameters.
- `clk`  in  1  Clock. All logic is on the rising edge.
- `reset`  in  1  One clock; reset is synchronous and active-low.
- `in_valid`  in  1  `in_int` and `in_unsigned` are valid.
- `in_ready`  out  1  Block can accept an input. High only in IDLE, and forced low while `reset` = 0.
- `in_int`  in  32  Integer operand.
- `in_unsigned`  in  1  1: treat `in_int` as unsigned. 0: treat it as two's complement.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  Consumer accepts `result`.
- `result`  out  32  FP32 result. Registered.

## Operation
- States: IDLE, NORM, ROUND, DONE.
- **IDLE** (`in_ready` = 1). On `in_valid`, capture the operand:
  - If `in_int` = 0: `result` = 0x00000000 (always +0), go to DONE.
  - Otherwise: `sign` = `in_int[31] & ~in_unsigned`.
  - `mag` is a 32-bit unsigned value: `mag` = `sign ? -in_int : in_int`. For 0x80000000 signed, `mag` = 0x80000000, with no overflow handling needed.
  - `exp` = 158 (127+31). Go to NORM.
- **NORM**:
  - If `mag[31]` = 1, go to ROUND.
  - Otherwise, per cycle: `mag <<= 1` and `exp -= 1`.
  - The block spends `lz`+1 cycles in NORM, where `lz` is the count of leading zeros of `mag` (0..31).
- **ROUND**:
  - `mant` = `mag[30:8]`, guard = `mag[7]`, sticky = `|mag[6:0]`.
  - Round up if guard & (sticky | `mant[0]`).
  - Compute the increment in 24 bits. On carry-out, `mant` = 0 and `exp` += 1.
  - `result` = {`sign`, `exp`, `mant`}. Go to DONE.
  - `exp` never exceeds 159, so overflow is impossible and no subnormal or NaN output can occur.
- **DONE** (`out_valid` = 1):
  - `result` is held stable.
  - On `out_ready` = 1, go to IDLE.
  - No new input is accepted in the same cycle.
- Widths: `exp` is 8 bits, `mag` is 32 bits, and the rounding adder is 24 bits.

## Timing
- **Reset values** (`reset` = 0 at a clock edge): state = IDLE, `out_valid` = 0, `result` = 0x00000000. `in_ready` is low while `reset` is held low and high from the first cycle after release.
- **Reset mid-operation** (any state): the operation is abandoned and no output is produced. `out_valid` = 0 after the edge.
- **Accept**: an input is accepted on a rising edge with `in_valid` & `in_ready`. Call this edge E0.
- **Zero input latency**: `out_valid` is high from E0, i.e. in the cycle right after acceptance.
- **Nonzero input latency**: `out_valid` rises at edge E0+`lz`+2. The fastest case is `lz` = 0 (2 edges); the slowest is `lz` = 31 (33 edges).
- **Output handshake**:
  - Output completes on an edge with `out_valid` & `out_ready`.
  - `in_ready` rises in the following cycle.
  - Minimum initiation interval is `lz`+4 cycles.
- **Backpressure**: while `out_ready` = 0, `out_valid` and `result` are held indefinitely.
- **During busy states**: `in_valid` and `in_int` are ignored in NORM, ROUND and DONE.

## Test plan
- **Smallest and sign cases.**
  - Signed 0x00000001 -> `result` 0x3F800000, `out_valid` at E0+33.
  - Signed 0xFFFFFFFF (-1) -> 0xBF800000.
- **Most-negative vs. unsigned.**
  - Signed 0x80000000 -> 0xCF000000 at E0+2.
  - Unsigned 0x80000000 -> 0x4F000000.
- **Rounding.**
  - 0x01000001 -> tie rounds to even: 0x4B800000.
  - 0x01000003 -> tie rounds up: 0x4B800002.
  - Unsigned 0xFFFFFFFF -> mantissa carry, exponent bump: 0x4F800000.
- **Zero.** 0x00000000 (either mode) -> 0x00000000 with `out_valid` in the cycle after E0.
- **Handshake.**
  - Hold `out_ready` = 0 for 10 cycles after `out_valid` -> `result` is stable and `in_ready` stays 0.
  - Toggle `in_valid`/`in_int` during NORM -> the conversion is unaffected.
  - Back-to-back inputs are each converted exactly once.
- **Reset.** Assert `reset` = 0 for one edge during NORM of input 0x00000001 -> IDLE, `out_valid` = 0, `result` = 0, and no output for the aborted input. The next input converts correctly.
